// File: rtl/load_unit_pkg.sv
// Shared definitions for the RV32E load sequencer: funct3 load encodings,
// sequencer states and memory read byte counts.
package load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] BYTES_1 = 3'd1;
    localparam logic [2:0] BYTES_2 = 3'd2;
    localparam logic [2:0] BYTES_4 = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } load_state_e;

    // Byte count handed to mem_controller; 0 marks an illegal funct3.
    function automatic logic [2:0] read_bytes_for(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return BYTES_1;
            F3_LH, F3_LHU: return BYTES_2;
            F3_LW:         return BYTES_4;
            default:       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-fetch handshake between load_unit (master) and mem_controller (slave).
interface load_unit_if #(
    parameter int ADDR_WIDTH = 24
) ();

    logic [ADDR_WIDTH-1:0] mem_target_address;
    logic [2:0]            mem_read_bytes;
    logic                  mem_is_data_fetch;
    logic                  mem_start_request;
    logic                  mem_request_done;
    logic [31:0]           mem_fetched_data;

    modport master (
        output mem_target_address,
        output mem_read_bytes,
        output mem_is_data_fetch,
        output mem_start_request,
        input  mem_request_done,
        input  mem_fetched_data
    );

    modport slave (
        input  mem_target_address,
        input  mem_read_bytes,
        input  mem_is_data_fetch,
        input  mem_start_request,
        output mem_request_done,
        output mem_fetched_data
    );

endinterface

// File: rtl/load_unit_extend.sv
// load_extend: turns a raw little-endian memory word into the register value
// for a given load type. Purely combinational, also used by forwarding.
module load_extend
    import load_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw_word,
    output logic [31:0] ext_word
);

    always_comb begin
        ext_word = raw_word;
        case (funct3)
            F3_LB:   ext_word = {{24{raw_word[7]}}, raw_word[7:0]};
            F3_LBU:  ext_word = {24'd0, raw_word[7:0]};
            F3_LH:   ext_word = {{16{raw_word[15]}}, raw_word[15:0]};
            F3_LHU:  ext_word = {16'd0, raw_word[15:0]};
            default: ext_word = raw_word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: sequences RV32E loads from the execute stage through the
// mem_controller data-fetch handshake and returns the extended result.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_addr,
    input  logic [11:0] offset,
    output logic        load_done,
    output logic [31:0] load_data,
    output logic        load_error,
    load_unit_if.master mem
);

    load_state_e           state_q, state_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  load_error_q, load_error_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            bytes_q, bytes_d;
    logic [2:0]            f3_q, f3_d;

    logic [31:0] ea;
    logic [31:0] ext_word;
    logic        bad_load;

    load_extend u_extend (
        .funct3   (f3_q),
        .raw_word (mem.mem_fetched_data),
        .ext_word (ext_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            load_data_q  <= '0;
            load_error_q <= 1'b0;
            addr_q       <= '0;
            bytes_q      <= '0;
            f3_q         <= '0;
        end else begin
            state_q      <= state_d;
            load_data_q  <= load_data_d;
            load_error_q <= load_error_d;
            addr_q       <= addr_d;
            bytes_q      <= bytes_d;
            f3_q         <= f3_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_data_d  = load_data_q;
        load_error_d = load_error_q;
        addr_d       = addr_q;
        bytes_d      = bytes_q;
        f3_d         = f3_q;

        ea       = base_addr + {{20{offset[11]}}, offset};
        // Illegal funct3 yields a zero byte count, so it shares the error path.
        bad_load = (read_bytes_for(funct3) == 3'd0)
                || (((funct3 == F3_LH) || (funct3 == F3_LHU)) && ea[0])
                || ((funct3 == F3_LW) && (ea[1:0] != 2'b00))
                || ((ea >> ADDR_WIDTH) != 32'd0);

        unique case (state_q)
            IDLE: begin
                if (load_start && !mem.mem_request_done) begin
                    load_data_d  = '0;
                    load_error_d = bad_load;
                    if (bad_load) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = ea[ADDR_WIDTH-1:0];
                        bytes_d = read_bytes_for(funct3);
                        f3_d    = funct3;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.mem_request_done) begin
                    load_data_d = ext_word;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!load_start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_done              = (state_q == DONE);
        load_data              = load_data_q;
        load_error             = load_error_q;
        mem.mem_start_request  = (state_q == REQ);
        mem.mem_target_address = addr_q;
        mem.mem_read_bytes     = bytes_q;
        mem.mem_is_data_fetch  = 1'b1;
    end

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit with a byte-addressed memory
// model standing in for mem_controller.
module tb_load_unit;
    import load_unit_pkg::*;

    localparam int ADDR_WIDTH = 24;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            bytes;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [2:0]  funct3;
    logic [31:0] base_addr;
    logic [11:0] offset;
    logic        load_done;
    logic [31:0] load_data;
    logic        load_error;

    load_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) mem_if ();

    load_unit #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .funct3     (funct3),
        .base_addr  (base_addr),
        .offset     (offset),
        .load_done  (load_done),
        .load_data  (load_data),
        .load_error (load_error),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    resp_t      resp_q[$];
    req_t       req_q[$];
    bit [7:0]   mem_over[int unsigned];
    int         checks_total  = 0;
    int         checks_passed = 0;
    int         hold_force    = -1;
    bit         stall_mem     = 1'b0;

    function automatic bit [7:0] mem_byte(input int unsigned a);
        if (mem_over.exists(a)) return mem_over[a];
        return 8'((a * 37) ^ (a >> 7) ^ 32'h5a);
    endfunction

    // Reference: what a load returns, straight from the ISA rules.
    function automatic resp_t model_load(input bit [2:0] f3, input bit [31:0] base,
                                         input bit [11:0] off, output bit issues_req,
                                         output req_t req);
        resp_t       r;
        int signed   off_s;
        int unsigned ea;
        int unsigned size;
        bit [31:0]   raw;
        int          v;
        off_s = $signed(off);
        ea    = base + 32'(off_s);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        r.err = (size == 0);
        if (!r.err) r.err = ((ea % size) != 0) || (longint'(ea) >= (64'd1 << ADDR_WIDTH));
        issues_req = !r.err;
        req.addr   = ADDR_WIDTH'(ea);
        req.bytes  = 3'(size);
        r.data     = 32'd0;
        if (!r.err) begin
            raw = 32'd0;
            for (int i = 0; i < int'(size); i++) raw[8*i +: 8] = mem_byte(ea + i);
            case (f3)
                3'd0: begin v = $signed(raw[7:0]);  r.data = v; end
                3'd1: begin v = $signed(raw[15:0]); r.data = v; end
                3'd4: r.data = raw & 32'hFF;
                3'd5: r.data = raw & 32'hFFFF;
                default: r.data = raw;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] build_word(input int unsigned addr, input int unsigned bytes);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = (i < int'(bytes)) ? mem_byte(addr + i) : 8'($urandom);
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic timeoutFail(input string name);
        checks_total++;
        $display("[TB] FAIL %s: got timeout expected event", name);
    endtask

    // mem_controller stand-in: random latency, done held a few cycles past the request.
    initial begin
        int delay = -1;
        int hold  = -1;
        mem_if.mem_request_done = 1'b0;
        mem_if.mem_fetched_data = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mem_if.mem_request_done = 1'b0;
                delay = -1;
                hold  = -1;
            end else if (mem_if.mem_start_request && !mem_if.mem_request_done && !stall_mem) begin
                if (delay < 0) delay = $urandom_range(0, 3);
                if (delay == 0) begin
                    mem_if.mem_fetched_data = build_word(mem_if.mem_target_address,
                                                         mem_if.mem_read_bytes);
                    mem_if.mem_request_done = 1'b1;
                    delay = -1;
                end else delay--;
            end else if (mem_if.mem_request_done && !mem_if.mem_start_request) begin
                if (hold < 0) hold = (hold_force >= 0) ? hold_force : $urandom_range(0, 2);
                if (hold == 0) begin
                    mem_if.mem_request_done = 1'b0;
                    hold = -1;
                end else hold--;
            end
        end
    end

    // Monitor: pops the scoreboard on each new request and each new result.
    initial begin
        bit    prev_done = 1'b0;
        bit    prev_req  = 1'b0;
        resp_t e;
        req_t  r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (load_done && !prev_done) begin
                    if (resp_q.size() == 0) timeoutFail("unexpected_load_done");
                    else begin
                        e = resp_q.pop_front();
                        checkOutput("load_error", 64'(load_error), 64'(e.err));
                        checkOutput("load_data", 64'(load_data), 64'(e.data));
                    end
                end
                if (mem_if.mem_start_request && !prev_req) begin
                    if (req_q.size() == 0) timeoutFail("unexpected_mem_request");
                    else begin
                        r = req_q.pop_front();
                        checkOutput("mem_target_address", 64'(mem_if.mem_target_address), 64'(r.addr));
                        checkOutput("mem_read_bytes", 64'(mem_if.mem_read_bytes), 64'(r.bytes));
                        checkOutput("mem_is_data_fetch", 64'(mem_if.mem_is_data_fetch), 64'd1);
                    end
                end
            end
            prev_done = load_done;
            prev_req  = mem_if.mem_start_request;
        end
    end

    task automatic applyStimulus(input bit [2:0] f3, input bit [31:0] base,
                                 input bit [11:0] off, input bit drop_early);
        resp_t e;
        req_t  r;
        bit    req;
        int    n;
        n = 0;
        while (mem_if.mem_request_done && n < 50) begin @(negedge clk); n++; end
        e = model_load(f3, base, off, req, r);
        resp_q.push_back(e);
        if (req) req_q.push_back(r);
        funct3     = f3;
        base_addr  = base;
        offset     = off;
        load_start = 1'b1;
        @(posedge clk); #1;
        if (e.err)
            checkOutput("error_latency", 64'({load_done, load_error, mem_if.mem_start_request}), 64'(3'b110));
        else
            checkOutput("request_latency", 64'({mem_if.mem_start_request, load_done}), 64'(2'b10));
        funct3    = 3'($urandom);
        base_addr = $urandom;
        offset    = 12'($urandom);
        if (drop_early && !e.err) begin @(negedge clk); load_start = 1'b0; end
        n = 0;
        while (!load_done && n < 100) begin @(negedge clk); n++; end
        if (!load_done) timeoutFail("load_done_wait");
        if (drop_early && !e.err) begin
            @(posedge clk); #1;
            checkOutput("done_one_cycle", 64'(load_done), 64'd0);
        end else begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                checkOutput("done_held", 64'(load_done), 64'd1);
            end
            @(negedge clk); load_start = 1'b0;
            @(posedge clk); #1;
            checkOutput("done_released", 64'(load_done), 64'd0);
        end
        checkOutput("data_hold", 64'({load_error, load_data}), 64'({e.err, e.data}));
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk); rst_n = 1'b0; load_start = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_outputs", 64'({load_done, load_error, load_data, mem_if.mem_start_request,
                    mem_if.mem_target_address, mem_if.mem_read_bytes}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resp_t e;
        req_t  r;
        bit    req;
        int    n;
        bit [2:0]  f3;
        bit [31:0] base;
        bit [11:0] off;

        rst_n = 1'b0; load_start = 1'b0; funct3 = 3'd0; base_addr = 32'd0; offset = 12'd0;
        repeat (2) @(posedge clk);
        resetDut();

        mem_over[32'h104] = 8'hEF; mem_over[32'h105] = 8'hBE;
        mem_over[32'h106] = 8'hAD; mem_over[32'h107] = 8'hDE;
        mem_over[32'h203] = 8'h80;
        mem_over[32'h400] = 8'h01; mem_over[32'h401] = 8'h80;

        applyStimulus(F3_LW,  32'h100, 12'd4, 1'b0);
        checkOutput("lw_deadbeef", 64'(load_data), 64'h0000_0000_DEAD_BEEF);
        applyStimulus(F3_LB,  32'h200, 12'd3, 1'b0);
        checkOutput("lb_sign", 64'(load_data), 64'h0000_0000_FFFF_FF80);
        applyStimulus(F3_LBU, 32'h200, 12'd3, 1'b0);
        checkOutput("lbu_zero", 64'(load_data), 64'h0000_0000_0000_0080);
        applyStimulus(F3_LH,  32'h11, 12'd0, 1'b0);
        applyStimulus(F3_LW,  32'h100, 12'd2, 1'b0);
        applyStimulus(F3_LB,  32'h0100_0000, 12'd0, 1'b0);
        applyStimulus(F3_LB,  32'h0, 12'hFFF, 1'b0);
        applyStimulus(3'd3,   32'h100, 12'd0, 1'b0);
        applyStimulus(3'd6,   32'h100, 12'd0, 1'b0);
        applyStimulus(3'd7,   32'h100, 12'd0, 1'b0);
        applyStimulus(F3_LH,  32'h500, 12'hFFE, 1'b1);

        // Back-to-back: memory keeps done high, the second load must wait for it.
        hold_force = 8;
        applyStimulus(F3_LW, 32'h300, 12'd0, 1'b0);
        e = model_load(F3_LHU, 32'h400, 12'd0, req, r);
        resp_q.push_back(e); req_q.push_back(r);
        funct3 = F3_LHU; base_addr = 32'h400; offset = 12'd0; load_start = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_waits_for_done_low", 64'({mem_if.mem_request_done, mem_if.mem_start_request}), 64'(2'b10));
        hold_force = -1;
        n = 0;
        while (!load_done && n < 100) begin @(negedge clk); n++; end
        if (!load_done) timeoutFail("b2b_done_wait");
        @(negedge clk); load_start = 1'b0;
        @(negedge clk);

        // Reset while the request is outstanding.
        stall_mem = 1'b1;
        n = 0;
        while (mem_if.mem_request_done && n < 50) begin @(negedge clk); n++; end
        e = model_load(F3_LW, 32'h600, 12'd0, req, r);
        resp_q.push_back(e); req_q.push_back(r);
        funct3 = F3_LW; base_addr = 32'h600; offset = 12'd0; load_start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("req_before_reset", 64'(mem_if.mem_start_request), 64'd1);
        resetDut();
        stall_mem = 1'b0;
        if (resp_q.size() > 0) void'(resp_q.pop_back());
        applyStimulus(F3_LHU, 32'h400, 12'd0, 1'b0);
        checkOutput("lhu_after_reset", 64'(load_data), 64'h0000_0000_0000_8001);

        for (int i = 0; i < 60; i++) begin
            f3   = 3'($urandom_range(0, 7));
            base = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'hFF_FFFF));
            off  = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                base = base & 32'hFFFF_FFFC;
                off  = 12'd0;
            end
            applyStimulus(f3, base, off, $urandom_range(0, 3) == 0);
        end

        repeat (5) @(negedge clk);
        checkOutput("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        checkOutput("req_queue_empty", 64'(req_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
